// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;
  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } ifetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch FIFO of fetch_entry_t; flush wins over push/pop, push+pop honoured when full.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  fetch_entry_t             i_data,
  input  logic                     i_pop,
  output fetch_entry_t             o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t    r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            w_do_push;
  logic            w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, single-outstanding imem req/ack, prefetch FIFO, redirect flush.
// Optional IFETCH_MISALIGN_EN: misaligned redirect sets sticky misalign and halts fetch.
module inst_fetch
  import ifetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic            misalign,
  output ifetch_state_t   o_dbg_state
);
  // Handshake: imem_req/imem_addr hold until the edge with imem_ack=1, which completes
  // the transfer; decoder side pops the head on any edge with inst_valid && inst_ready.
  localparam int CW = $clog2(DEPTH) + 1;

  ifetch_state_t   r_state, w_state_next;
  logic [XLEN-1:0] r_pc, w_pc_next;
  logic            r_req, w_req_next;
  logic [XLEN-1:0] r_addr;
  logic            w_hold;
  logic            w_ack_done;
  logic            w_push, w_pop, w_flush, w_fifo_push;
  logic [CW-1:0]   w_count, w_count_next;
  logic            w_full, w_empty;
  logic [XLEN-1:0] w_redirect_pc;
  fetch_entry_t    w_head;

  assign w_redirect_pc = redirect_pc & ~32'h3;
  assign w_ack_done    = r_req && imem_ack;
  assign w_hold        = r_req && !imem_ack;
  assign w_pop         = inst_valid && inst_ready;
  assign w_fifo_push   = w_push && (!w_full || w_pop);

`ifdef IFETCH_MISALIGN_EN
  logic r_misalign, w_set_misalign, w_misaligned;
  assign w_misaligned = (redirect_pc[1:0] != 2'b00);
  assign misalign     = r_misalign;
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_push       = 1'b0;
    w_flush      = 1'b0;
`ifdef IFETCH_MISALIGN_EN
    w_set_misalign = 1'b0;
`endif
    unique case (r_state)
      FETCH: begin
        if (redirect) begin
          w_flush   = 1'b1;
          w_pc_next = w_redirect_pc;
          if (w_hold) w_state_next = DRAIN;
`ifdef IFETCH_MISALIGN_EN
          if (w_misaligned) begin
            w_state_next   = HALT;
            w_set_misalign = 1'b1;
          end
`endif
        end else if (w_ack_done) begin
          w_push    = 1'b1;
          w_pc_next = r_pc + XLEN'(INST_BYTES);
        end
      end
      DRAIN: begin
        // The stale response is dropped; the FIFO is already empty from the redirect.
        if (w_ack_done) w_state_next = FETCH;
        if (redirect) begin
          w_flush   = 1'b1;
          w_pc_next = w_redirect_pc;
`ifdef IFETCH_MISALIGN_EN
          if (w_misaligned) begin
            w_state_next   = HALT;
            w_set_misalign = 1'b1;
          end
`endif
        end
      end
      HALT:    w_flush = 1'b1;
      default: w_state_next = FETCH;
    endcase
  end

  assign w_count_next = w_flush ? '0 : (w_count + CW'(w_fifo_push) - CW'(w_pop));
  // New request only when the entry it will produce is guaranteed a FIFO slot.
  assign w_req_next   = w_hold || ((w_state_next == FETCH) && (w_count_next < CW'(DEPTH)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_req   <= 1'b0;
      r_addr  <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_req   <= w_req_next;
      if (!w_hold) r_addr <= w_pc_next;
    end
  end

`ifdef IFETCH_MISALIGN_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                r_misalign <= 1'b0;
    else if (w_set_misalign) r_misalign <= 1'b1;
  end
`endif

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_flush (w_flush),
    .i_push  (w_fifo_push),
    .i_data  ({imem_rdata, r_pc}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign inst        = w_head.inst;
  assign inst_pc     = w_head.pc;
  assign inst_valid  = !w_empty;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: memory responder, expected-entry queue, per-scenario tasks.
`timescale 1ns/1ps
module tb_inst_fetch;
  import ifetch_pkg::*;

  localparam int          DEPTH   = 4;
  localparam logic [31:0] XOR_KEY = 32'hA5A5_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req, imem_ack;
  logic [31:0]   imem_addr, imem_rdata;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic [31:0]   inst, inst_pc;
  logic          inst_valid, inst_ready, misalign;
  ifetch_state_t dbg_state;

  always #5 clk = ~clk;

  inst_fetch #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .misalign    (misalign),
    .o_dbg_state (dbg_state)
  );

  logic [63:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          mem_lat = 0;
  int          wait_cnt = 0;
  int          n_acks = 0;
  int          n_pops = 0;
  logic [31:0] m_pc = '0;
  bit          m_drop = 1'b0;
  bit          m_halt = 1'b0;
  logic        s_req, s_ack;
  logic [31:0] s_addr;

  // One clock: respond to memory and score pops at negedge, return 1ns after posedge.
  task automatic tick();
    logic [63:0] exp_e;
    @(negedge clk);
    s_req  = imem_req;
    s_addr = imem_addr;
    if (imem_req && wait_cnt >= mem_lat) begin
      imem_ack   = 1'b1;
      imem_rdata = imem_addr ^ XOR_KEY;
      wait_cnt   = 0;
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom();
      wait_cnt   = imem_req ? wait_cnt + 1 : 0;
    end
    s_ack = imem_ack;
    if (inst_valid && inst_ready && !redirect) begin
      n_pops++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got pc=%h inst=%h, required no valid instruction", inst_pc, inst);
      end else begin
        exp_e = exp_q.pop_front();
        if ({inst, inst_pc} !== exp_e) begin
          n_err++;
          $display("FAIL sb_entry: got pc=%h inst=%h, required pc=%h inst=%h",
                   inst_pc, inst, exp_e[31:0], exp_e[63:32]);
        end
      end
    end
    if (imem_ack) begin
      n_acks++;
      if (m_drop) m_drop = 1'b0;
      else if (!redirect && !m_halt) begin
        n_vec++;
        if (imem_addr !== m_pc) begin
          n_err++;
          $display("FAIL sb_addr: got imem_addr=%h, required %h", imem_addr, m_pc);
        end
        exp_q.push_back({m_pc ^ XOR_KEY, m_pc});
        m_pc = m_pc + 32'd4;
      end
    end
    if (redirect && !m_halt) begin
      exp_q.delete();
      m_pc = redirect_pc & ~32'h3;
      if (imem_req && !imem_ack) m_drop = 1'b1;
`ifdef IFETCH_MISALIGN_EN
      if (redirect_pc[1:0] != 2'b00) m_halt = 1'b1;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input string name);
    int k;
    k = 0;
    s_ack = 1'b0;
    while (!s_ack && k < 12) begin
      tick();
      k++;
    end
    n_vec++;
    if (!s_ack) begin
      n_err++;
      $display("FAIL %s_timeout: got no ack in %0d cycles, required ack", name, k);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; imem_ack = 1'b0; imem_rdata = '0; redirect = 1'b0; redirect_pc = '0;
    inst_ready = 1'b0; mem_lat = 0; wait_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b, required 0", imem_req); end
    n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h, required 0", imem_addr); end
    n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b, required 0", inst_valid); end
    n_vec++; if ({inst, inst_pc} !== 64'h0) begin n_err++; $display("FAIL rst_inst: got %h/%h, required 0/0", inst, inst_pc); end
    n_vec++; if (misalign !== 1'b0) begin n_err++; $display("FAIL rst_misalign: got %b, required 0", misalign); end
    n_vec++; if (dbg_state !== FETCH) begin n_err++; $display("FAIL rst_state: got %0d, required FETCH", dbg_state); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    m_pc = 32'h0; m_drop = 1'b0; m_halt = 1'b0; exp_q.delete();
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_err++; $display("FAIL rst_first_req: got req=%b addr=%h, required 1/0", imem_req, imem_addr);
    end
  endtask

  task automatic test_backpressure();
    inst_ready = 1'b0; mem_lat = 0; n_acks = 0;
    n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL bp_pre_valid: got %b, required 0", inst_valid); end
    tick();
    n_vec++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL bp_first_valid: got %b, required 1", inst_valid); end
    repeat (7) tick();
    n_vec++; if (n_acks != DEPTH) begin n_err++; $display("FAIL bp_acks: got %0d, required %0d", n_acks, DEPTH); end
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL bp_req_off: got %b, required 0", imem_req); end
    inst_ready = 1'b1; n_pops = 0;
    tick();
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      n_err++; $display("FAIL bp_resume: got req=%b addr=%h, required 1/00000010", imem_req, imem_addr);
    end
    repeat (3) tick();
    n_vec++; if (n_pops != 4) begin n_err++; $display("FAIL bp_pops: got %0d, required 4", n_pops); end
  endtask

  task automatic test_stream();
    inst_ready = 1'b1; mem_lat = 0; n_acks = 0; n_pops = 0;
    repeat (16) tick();
    n_vec++; if (n_pops != 16) begin n_err++; $display("FAIL stream_pops: got %0d, required 16", n_pops); end
    n_vec++; if (n_acks != 16) begin n_err++; $display("FAIL stream_acks: got %0d, required 16", n_acks); end
  endtask

  task automatic test_wait_states();
    logic [31:0] a0;
    mem_lat = 3; n_acks = 0; a0 = m_pc;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if (s_req !== 1'b1 || s_addr !== a0 || s_ack !== (i == 3)) begin
        n_err++;
        $display("FAIL wait_hold%0d: got req=%b addr=%h ack=%b, required 1/%h/%b", i, s_req, s_addr, s_ack, a0, (i == 3));
      end
    end
    n_vec++; if (n_acks != 1) begin n_err++; $display("FAIL wait_pushes: got %0d, required 1", n_acks); end
  endtask

  task automatic test_redirect_drain();
    mem_lat = 3; inst_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h8;
    tick();
    redirect = 1'b0;
    n_vec++; if (dbg_state !== DRAIN) begin n_err++; $display("FAIL drain_enter1: got %0d, required DRAIN", dbg_state); end
    wait_ack("drain1");
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8 || dbg_state !== FETCH) begin
      n_err++; $display("FAIL drain_exit1: got req=%b addr=%h st=%0d, required 1/00000008/FETCH", imem_req, imem_addr, dbg_state);
    end
    tick();
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    n_vec++; if (dbg_state !== DRAIN) begin n_err++; $display("FAIL drain_enter2: got %0d, required DRAIN", dbg_state); end
    wait_ack("drain2");
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_err++; $display("FAIL drain_target: got req=%b addr=%h, required 1/00000100", imem_req, imem_addr);
    end
    mem_lat = 0;
    repeat (4) tick();
  endtask

  task automatic test_redirect_ack_pop();
    mem_lat = 0; inst_ready = 1'b1;
    repeat (2) tick();
    n_vec++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL rap_pre_valid: got %b, required 1", inst_valid); end
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    n_vec++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200 || dbg_state !== FETCH) begin
      n_err++; $display("FAIL rap_flush: got v=%b req=%b addr=%h st=%0d, required 0/1/00000200/FETCH",
                        inst_valid, imem_req, imem_addr, dbg_state);
    end
    tick();
    n_vec++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h200 || inst !== (32'h200 ^ XOR_KEY)) begin
      n_err++; $display("FAIL rap_head: got v=%b pc=%h inst=%h, required 1/00000200/%h", inst_valid, inst_pc, inst, 32'h200 ^ XOR_KEY);
    end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    repeat (6) tick();
    n_vec++; if (imem_addr !== 32'h10) begin n_err++; $display("FAIL wrap_addr: got %h, required 00000010", imem_addr); end
  endtask

  task automatic test_misalign();
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    tick();
    redirect = 1'b0;
`ifdef IFETCH_MISALIGN_EN
    n_vec++; if (misalign !== 1'b1) begin n_err++; $display("FAIL mis_flag: got %b, required 1", misalign); end
    repeat (4) tick();
    n_vec++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 || dbg_state !== HALT) begin
      n_err++; $display("FAIL mis_halt: got req=%b v=%b st=%0d, required 0/0/HALT", imem_req, inst_valid, dbg_state);
    end
`else
    n_vec++;
    if (misalign !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_err++; $display("FAIL mis_clear: got mis=%b req=%b addr=%h, required 0/1/00000100", misalign, imem_req, imem_addr);
    end
    repeat (4) tick();
`endif
  endtask

  task automatic test_reset_mid();
    rst = 1'b0;
    #1;
    n_vec++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== 32'h0 || misalign !== 1'b0 || dbg_state !== FETCH) begin
      n_err++; $display("FAIL midrst_vals: got req=%b v=%b addr=%h mis=%b st=%0d, required 0/0/0/0/FETCH",
                        imem_req, inst_valid, imem_addr, misalign, dbg_state);
    end
    @(negedge clk);
    imem_ack = 1'b0; wait_cnt = 0; rst = 1'b1;
    m_pc = 32'h0; m_drop = 1'b0; m_halt = 1'b0; exp_q.delete();
    @(posedge clk);
    #1;
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_err++; $display("FAIL midrst_req: got req=%b addr=%h, required 1/0", imem_req, imem_addr);
    end
    inst_ready = 1'b1; mem_lat = $urandom_range(0, 2);
    repeat (12) tick();
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_stream();
    test_wait_states();
    test_redirect_drain();
    test_redirect_ack_pop();
    test_wrap();
    test_misalign();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage feeding the `inst` input of `processor`. It holds the program counter, issues single-outstanding word reads to instruction memory over a req/ack handshake, and buffers returned words in a small prefetch FIFO. The decoder side sees a valid/ready stream of instructions, each tagged with its PC. A redirect input flushes the buffer and restarts fetch at a new address.

## Interface
- `DEPTH`, 4: prefetch FIFO entries; power of two, 2..16.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted at 0).
- `imem_req`  out  1  read request to instruction memory.
- `imem_addr`  out  32  word address of the current request; bits [1:0] always 0.
- `imem_ack`  in  1  memory accepts the request and returns data this cycle.
- `imem_rdata`  in  32  instruction word; valid only when `imem_ack`=1.
- `redirect`  in  1  single-cycle pulse: flush and restart fetch.
- `redirect_pc`  in  32  new fetch address, sampled when `redirect`=1.
- `inst`  out  32  FIFO head instruction to the decoder.
- `inst_pc`  out  32  address of `inst`.
- `inst_valid`  out  1  `inst`/`inst_pc` hold a real instruction.
- `inst_ready`  in  1  consumer accepts the head this cycle.
- `misalign`  out  1  sticky misaligned-redirect flag (see Configuration).

## Operation
- States: FETCH (request may be issued), DRAIN (discard one outstanding response after redirect), HALT (misalign only).
- Reset values: `imem_req`=0, `imem_addr`=RESET_PC, `inst`=0, `inst_pc`=0, `inst_valid`=0, `misalign`=0, FIFO empty, state FETCH, `pc`=RESET_PC.
- Memory handshake: once `imem_req`=1 is driven, `imem_req` and `imem_addr` stay stable until a cycle with `imem_ack`=1. The transfer completes on that edge. Only one request is outstanding at a time.
- Issue rule in FETCH: drive `imem_req`=1 with `imem_addr`=`pc` when (FIFO count + in-flight) < DEPTH. On ack, push {`imem_rdata`, `pc`} and set `pc`=`pc`+4. The 32-bit PC wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
- Consumer side: `inst_valid`=!empty. The head pops on an edge where `inst_valid`&&`inst_ready`. Push and pop in the same cycle are both honoured, including when the FIFO is full and when it holds exactly one entry.
- Redirect (highest priority): on the edge with `redirect`=1:
  - FIFO is cleared; a same-cycle pop and push are discarded.
  - `pc` is loaded with `{redirect_pc[31:2],2'b00}`.
  - If a request is pending and not acked that cycle, the state goes to DRAIN. DRAIN holds the old req/addr until ack, drops the data, then returns to FETCH.
  - If ack coincides with redirect, the data is dropped and the state stays FETCH.
  - A redirect during DRAIN updates `pc` only; the state stays DRAIN.
- `inst_valid` never asserts for data fetched before a redirect.

## Timing
- First `imem_req` is driven in the first cycle after `rst` deasserts.
- Ack on edge N pushes to the FIFO. `inst_valid` is 1 in cycle N+1 (registered output, 1-cycle latency).
- With zero-wait memory (ack in the same cycle as req), the block sustains 1 instruction/cycle while the consumer is ready.
- After a redirect with no request pending, the target address appears on `imem_addr` with `imem_req`=1 in the next cycle.
- Reset mid-operation forces the reset values immediately (asynchronous) and abandons any outstanding request.

## Configuration
- `IFETCH_MISALIGN_EN` defined:
  - A redirect with `redirect_pc[1:0]`≠0 sets `misalign`=1 and enters HALT.
  - In HALT: no requests are issued, the FIFO is flushed, and `inst_valid`=0.
  - Only reset exits HALT.
  - If a request is pending on entry, HALT still completes that handshake and discards the data.
- `IFETCH_MISALIGN_EN` undefined: `misalign` is tied 0 and the low bits are silently cleared.

## Structure
- Package `ifetch_pkg` holds:
  - `XLEN`=32
  - `INST_BYTES`=4
  - state enum `ifetch_state_t` {FETCH, DRAIN, HALT}
  - typedef `fetch_entry_t` {inst[31:0], pc[31:0]}
- Sub-module `ifetch_fifo`: synchronous FIFO of `fetch_entry_t` with DEPTH entries, flush, push/pop, count, and full/empty flags.

## Test plan
- Reset, zero-wait memory returning addr^32'hA5A5_0000, `inst_ready`=1 → addresses 0,4,8,… on consecutive cycles; `inst_pc`/`inst` pairs in order; first `inst_valid` appears 1 cycle after the first ack.
- `inst_ready`=0, DEPTH=4 → exactly 4 acks, then `imem_req`=0. Raise ready → 4 pops in 4 cycles, and requests resume at 32'h10.
- Ack delayed 3 cycles → `imem_req`/`imem_addr` stay stable for all 3 cycles; 1 push.
- Redirect to 32'h100 while a request to 32'h8 is pending → state DRAIN, the 32'h8 data is never visible, and the next request goes to 32'h100.
- Redirect coincident with ack and pop → FIFO empty next cycle; next `inst_pc`=redirect target.
- With `IFETCH_MISALIGN_EN`, redirect to 32'h102 → `misalign`=1, no further `imem_req`; `rst`=0 clears the flag.
